instruction_fetch_queue: RTL

Instruction fetch stage with prefetch buffer, sitting directly upstream of the decode/control path of the LEGv8 core. It owns the fetch PC, issues word requests to a variable-latency instruction memory over a req/ack handshake, and buffers returned instructions with their PCs in a small FIFO. Decode consumes entries over a valid/ready handshake. A branch redirect from the execute stage flushes the queue and restarts fetch at the target.

---
 rtl/instruction_fetch_queue_if.sv | 30 +++
 rtl/instruction_fetch_queue.sv | 117 +++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack, branch redirect and the
// valid/ready head-of-queue port toward decode.
interface instruction_fetch_queue_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_data,
    input  redirect, redirect_pc,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_data,
    output redirect, redirect_pc,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the fetch PC, keeps one request outstanding to instruction
// memory and buffers returned words with their PCs in a circular FIFO.
module instruction_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic                       clk,
  input logic                       reset_n,
  instruction_fetch_queue_if.master io_bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

  state_e          r_state, w_state_next;
  logic [63:0]     r_fpc;
  logic [63:0]     r_hold_addr;
  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0] r_count, w_count_next;
  logic [31:0]     r_instr [DEPTH];
  logic [63:0]     r_pc    [DEPTH];
  logic            w_push, w_pop, w_hold_load;
  logic [63:0]     w_target;

  assign w_target    = io_bus.redirect_pc & ~64'h3;
  assign w_pop       = (r_count != '0) & io_bus.out_ready;
  assign w_push      = (r_state == StReq) & io_bus.imem_ack & ~io_bus.redirect;
  // Redirect while a request waits: keep presenting the old address until acked.
  assign w_hold_load = (r_state == StReq) & io_bus.redirect & ~io_bus.imem_ack;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CntW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (!io_bus.redirect && (r_count < Full)) w_state_next = StReq;
      end
      StReq: begin
        if (io_bus.redirect) begin
          w_state_next = io_bus.imem_ack ? StIdle : StDrain;
        end else if (io_bus.imem_ack) begin
          w_state_next = (w_count_next < Full) ? StReq : StIdle;
        end
      end
      StDrain: begin
        if (io_bus.imem_ack) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    io_bus.imem_req  = (r_state != StIdle);
    io_bus.imem_addr = (r_state == StDrain) ? r_hold_addr : r_fpc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fpc       <= RESET_PC;
      r_hold_addr <= RESET_PC;
    end else begin
      if (w_hold_load) r_hold_addr <= r_fpc;
      if (io_bus.redirect) begin
        r_fpc <= w_target;
      end else if (w_push) begin
        r_fpc <= r_fpc + 64'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_instr  <= '{default: 32'h0};
      r_pc     <= '{default: 64'h0};
    end else if (io_bus.redirect) begin
      // Redirect overrides any same-cycle push or pop.
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_push) begin
        r_instr[r_wr_ptr] <= io_bus.imem_data;
        r_pc[r_wr_ptr]    <= r_fpc;
        r_wr_ptr          <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
    end
  end

  assign io_bus.out_valid = (r_count != '0);
  assign io_bus.out_instr = r_instr[r_rd_ptr];
  assign io_bus.out_pc    = r_pc[r_rd_ptr];

endmodule
